// File: rtl/tlc_timed.sv
// Highway/country traffic light controller with configurable yellow, all-red,
// minimum/maximum green timing and an emergency all-red override.
module tlc_timed #(
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned Y2R_DELAY       = 3,
   parameter int unsigned R2G_DELAY       = 2,
   parameter int unsigned HWY_MIN_GREEN   = 8,
   parameter int unsigned CNTRY_MAX_GREEN = 10
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       X,
   input  logic       emergency,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_HG    = 3'd0,
      S_HY    = 3'd1,
      S_AR_C  = 3'd2,
      S_CG    = 3'd3,
      S_CY    = 3'd4,
      S_AR_H  = 3'd5,
      S_EMERG = 3'd6
   } state_e;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   // Terminal counts: a state lasting N cycles is left when the counter reads N-1.
   localparam logic [CNT_W-1:0] Y2R_LAST   = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] R2G_LAST   = CNT_W'(R2G_DELAY - 1);
   localparam logic [CNT_W-1:0] HWY_MIN_LAST = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CG_MAX_LAST  = CNT_W'(CNTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_clr;

   always_comb begin
      w_next = r_state;
      hwy    = RED;
      cntry  = RED;
      case (r_state)
         S_HG: begin
            hwy = GREEN;
            if (emergency || (X && (r_cnt >= HWY_MIN_LAST))) w_next = S_HY;
         end
         S_HY: begin
            hwy = YELLOW;
            // Yellow always runs its full time; emergency only picks the exit.
            if (r_cnt == Y2R_LAST) w_next = emergency ? S_EMERG : S_AR_C;
         end
         S_AR_C: begin
            if (emergency)              w_next = S_EMERG;
            else if (r_cnt == R2G_LAST) w_next = S_CG;
         end
         S_CG: begin
            cntry = GREEN;
            if (emergency || !X || (r_cnt == CG_MAX_LAST)) w_next = S_CY;
         end
         S_CY: begin
            cntry = YELLOW;
            if (r_cnt == Y2R_LAST) w_next = emergency ? S_EMERG : S_AR_H;
         end
         S_AR_H: begin
            if (emergency)              w_next = S_EMERG;
            else if (r_cnt == R2G_LAST) w_next = S_HG;
         end
         S_EMERG: begin
            if (!emergency && (r_cnt == R2G_LAST)) w_next = S_HG;
         end
         default: w_next = S_HG;
      endcase
   end

   // Holding the counter at 0 during emergency restarts clearance on each reassertion.
   assign w_cnt_clr = (w_next != r_state) || ((r_state == S_EMERG) && emergency);

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_HG;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_cnt_clr)             r_cnt <= '0;
         else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign state = r_state;

endmodule

// File: tb/tb_tlc_timed.sv
// Self-checking bench for tlc_timed: phase-timing reference model checked every
// cycle, directed timing pins, and randomized X/emergency/clear traffic.
module tb_tlc_timed;

   localparam int Y2R  = 3;
   localparam int R2G  = 2;
   localparam int HMIN = 8;
   localparam int CMAX = 10;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       X = 1'b0;
   logic       emergency = 1'b0;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   tlc_timed #(
      .CNT_W          (8),
      .Y2R_DELAY      (Y2R),
      .R2G_DELAY      (R2G),
      .HWY_MIN_GREEN  (HMIN),
      .CNTRY_MAX_GREEN(CMAX)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .X        (X),
      .emergency(emergency),
      .hwy      (hwy),
      .cntry    (cntry),
      .state    (state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: phase number, cycles spent in the phase, and cycles of
   // quiet (emergency low) accumulated while in the emergency phase.
   int  m_ph    = 0;
   int  m_el    = 0;
   int  m_quiet = 0;
   bit  m_valid = 0;
   int  hwy_of[7]   = '{2, 1, 0, 0, 0, 0, 0};
   int  cntry_of[7] = '{0, 0, 0, 2, 1, 0, 0};

   always @(posedge clock) begin
      int nx;
      nx = m_ph;
      if (clear) begin
         nx = 0;
         m_valid = 1;
      end else begin
         case (m_ph)
            0: if (emergency || (X && m_el + 1 >= HMIN)) nx = 1;
            1: if (m_el + 1 == Y2R) nx = emergency ? 6 : 2;
            2: if (emergency) nx = 6; else if (m_el + 1 == R2G) nx = 3;
            3: if (emergency || !X || m_el + 1 == CMAX) nx = 4;
            4: if (m_el + 1 == Y2R) nx = emergency ? 6 : 5;
            5: if (emergency) nx = 6; else if (m_el + 1 == R2G) nx = 0;
            default: begin
               if (emergency) m_quiet = 0;
               else if (m_quiet + 1 == R2G) nx = 0;
               else m_quiet++;
            end
         endcase
      end
      if (clear || nx != m_ph) begin
         m_el    = 0;
         m_quiet = 0;
      end else begin
         m_el++;
      end
      m_ph = nx;
   end

   // Single compare process, away from the active edge.
   always @(negedge clock) begin
      if (m_valid) begin
         chk("state", int'(state), m_ph);
         chk("hwy", int'(hwy), hwy_of[m_ph]);
         chk("cntry", int'(cntry), cntry_of[m_ph]);
         chk("safety", int'(hwy != 2'd0 && cntry != 2'd0), 0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear = 1'b1;
      X = 1'b0;
      emergency = 1'b0;
      repeat (2) tick();
      chk("reset_state", int'(state), 0);
      chk("reset_hwy", int'(hwy), 2);
      chk("reset_cntry", int'(cntry), 0);
      clear = 1'b0;
   endtask

   initial begin
      // Idle highway green with no traffic.
      do_reset();
      for (int k = 1; k <= 50; k++) begin
         tick();
         chk("idle_state", int'(state), 0);
      end

      // Continuous country demand: min green, yellow, all-red, max green, repeat.
      do_reset();
      X = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         tick();
         if (k == 7)  chk("hg_hold", int'(state), 0);
         if (k == 8)  chk("hy_at8", int'(state), 1);
         if (k == 11) chk("arc_at11", int'(state), 2);
         if (k == 13) chk("cg_at13", int'(cntry), 2);
         if (k == 22) chk("cg_at22", int'(state), 3);
         if (k == 23) chk("cy_at23", int'(state), 4);
         if (k == 26) chk("arh_at26", int'(state), 5);
         if (k == 28) chk("hg_at28", int'(state), 0);
         if (k == 36) chk("hy_at36", int'(state), 1);
      end

      // Country car leaves after 4 cycles of green.
      do_reset();
      X = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 16) begin
            chk("cg_at16", int'(state), 3);
            X = 1'b0;
         end
         if (k == 17) chk("cy_at17", int'(state), 4);
         if (k == 19) chk("cy_at19", int'(state), 4);
         if (k == 20) chk("arh_at20", int'(state), 5);
         if (k == 22) chk("hg_at22", int'(state), 0);
      end

      // Emergency burst of 10 cycles from highway green.
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 2)  emergency = 1'b1;
         if (k == 12) emergency = 1'b0;
         if (k == 3)  chk("em_hy_at3", int'(state), 1);
         if (k == 5)  chk("em_hy_full", int'(state), 1);
         if (k == 6)  begin
            chk("em_s6_at6", int'(state), 6);
            chk("em_lamps", int'(hwy) + int'(cntry), 0);
         end
         if (k == 13) chk("em_s6_at13", int'(state), 6);
         if (k == 14) chk("em_hg_at14", int'(state), 0);
      end

      // Clear in the middle of country yellow.
      do_reset();
      X = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 24) chk("cy_before_clr", int'(state), 4);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_state", int'(state), 0);
      chk("clr_hwy", int'(hwy), 2);
      chk("clr_cntry", int'(cntry), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 7) chk("clr_hold", int'(state), 0);
         if (k == 8) chk("clr_hy_at8", int'(state), 1);
      end

      // Long idle saturates the counter; minimum green is still satisfied.
      do_reset();
      repeat (300) tick();
      X = 1'b1;
      tick();
      chk("sat_hy", int'(state), 1);

      // Randomized traffic, emergencies and occasional clears.
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) < 12) X = ~X;
         if ($urandom_range(0, 99) < (emergency ? 15 : 2)) emergency = ~emergency;
         clear = ($urandom_range(0, 399) == 0);
         tick();
      end
      clear = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
